// File: rtl/slc3_pkg.sv
// Shared types and constants for the memory-side datapath blocks.
package slc3_pkg;
  localparam int BUS_W            = 16;
  localparam int DEFAULT_MEM_WAIT = 2;

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} mem_state_t;
endpackage

// File: rtl/mem_bus_sink_if.sv
// Bus-side and SRAM-side signals of the memory bus sink, grouped with driver/receiver views.
interface mem_bus_sink_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] Bus;
  logic             LD_MAR;
  logic             LD_MDR;
  logic             MIO_EN;
  logic             Mem_Req;
  logic             Mem_Wr;
  logic [WIDTH-1:0] Mem_RData;
  logic [WIDTH-1:0] MAR;
  logic [WIDTH-1:0] MDR;
  logic [WIDTH-1:0] Mem_Addr;
  logic [WIDTH-1:0] Mem_WData;
  logic             Mem_CE_N;
  logic             Mem_OE_N;
  logic             Mem_WE_N;
  logic             Busy;
  logic             Mem_Done;

  modport master (
    output Bus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_Wr, Mem_RData,
    input  MAR, MDR, Mem_Addr, Mem_WData, Mem_CE_N, Mem_OE_N, Mem_WE_N, Busy, Mem_Done
  );

  modport slave (
    input  Bus, LD_MAR, LD_MDR, MIO_EN, Mem_Req, Mem_Wr, Mem_RData,
    output MAR, MDR, Mem_Addr, Mem_WData, Mem_CE_N, Mem_OE_N, Mem_WE_N, Busy, Mem_Done
  );
endinterface

// File: rtl/ld_reg.sv
// Load-enabled register with synchronous active-high clear.
module ld_reg #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge i_clk) begin
    if (i_rst)     r_q <= '0;
    else if (i_ld) r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/mux_2t1.sv
// Two-input word mux.
module mux_2t1 #(
  parameter int WIDTH = 16
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_d0,
  input  logic [WIDTH-1:0] i_d1,
  output logic [WIDTH-1:0] o_y
);
  assign o_y = i_sel ? i_d1 : i_d0;
endmodule

// File: rtl/mem_bus_sink.sv
// Captures the datapath bus into MAR/MDR and sequences fixed-wait SRAM read/write accesses.
module mem_bus_sink
  import slc3_pkg::*;
#(
  parameter int WIDTH       = BUS_W,
  parameter int WAIT_CYCLES = DEFAULT_MEM_WAIT,
  parameter int CNT_W       = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  mem_bus_sink_if.slave bus
);
  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || WAIT_CYCLES >= (1 << CNT_W)) begin : g_bad_cfg
      $error("mem_bus_sink: WAIT_CYCLES out of range for CNT_W");
    end
  endgenerate

  mem_state_t       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_ce_n, r_oe_n, r_we_n, r_busy, r_done;

  logic             w_idle, w_last, w_rd_cap;
  logic             w_ld_mar, w_ld_mdr, w_mdr_sel;
  logic [WIDTH-1:0] w_mdr_d, w_mar, w_mdr;

  assign w_idle   = (r_state == IDLE);
  assign w_last   = (r_cnt == CNT_W'(WAIT_CYCLES - 1));
  assign w_rd_cap = (r_state == READ) && w_last;

  // Bus loads only in IDLE; the read capture is the one MDR write allowed while busy.
  assign w_ld_mar  = w_idle && bus.LD_MAR;
  assign w_ld_mdr  = (w_idle && bus.LD_MDR) || w_rd_cap;
  assign w_mdr_sel = w_rd_cap || bus.MIO_EN;

  mux_2t1 #(.WIDTH(WIDTH)) u_mdr_mux (
    .i_sel (w_mdr_sel),
    .i_d0  (bus.Bus),
    .i_d1  (bus.Mem_RData),
    .o_y   (w_mdr_d)
  );

  ld_reg #(.WIDTH(WIDTH)) u_mar (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_ld  (w_ld_mar),
    .i_d   (bus.Bus),
    .o_q   (w_mar)
  );

  ld_reg #(.WIDTH(WIDTH)) u_mdr (
    .i_clk (Clk),
    .i_rst (Reset),
    .i_ld  (w_ld_mdr),
    .i_d   (w_mdr_d),
    .o_q   (w_mdr)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Mem_Req) begin
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_ce_n <= 1'b0;
            if (bus.Mem_Wr) begin
              r_state <= WRITE;
              r_we_n  <= 1'b0;
            end else begin
              r_state <= READ;
              r_oe_n  <= 1'b0;
            end
          end
        end
        READ, WRITE: begin
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_state <= DONE;
            r_ce_n  <= 1'b1;
            r_oe_n  <= 1'b1;
            r_we_n  <= 1'b1;
            r_done  <= 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.MAR       = w_mar;
  assign bus.MDR       = w_mdr;
  assign bus.Mem_Addr  = w_mar;
  assign bus.Mem_WData = w_mdr;
  assign bus.Mem_CE_N  = r_ce_n;
  assign bus.Mem_OE_N  = r_oe_n;
  assign bus.Mem_WE_N  = r_we_n;
  assign bus.Busy      = r_busy;
  assign bus.Mem_Done  = r_done;
endmodule

// File: tb/tb_mem_bus_sink.sv
// Directed bench for mem_bus_sink: WAIT_CYCLES 2 for most scenarios, 1 and 3 for back-to-back.
module tb_mem_bus_sink;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  int   pass = 0;
  int   total = 0;

  always #5 Clk = ~Clk;

  mem_bus_sink_if #(.WIDTH(16)) b2 ();
  mem_bus_sink_if #(.WIDTH(16)) b1 ();
  mem_bus_sink_if #(.WIDTH(16)) b3 ();

  mem_bus_sink #(.WIDTH(16), .WAIT_CYCLES(2), .CNT_W(4)) dut2 (.Clk(Clk), .Reset(Reset), .bus(b2));
  mem_bus_sink #(.WIDTH(16), .WAIT_CYCLES(1), .CNT_W(4)) dut1 (.Clk(Clk), .Reset(Reset), .bus(b1));
  mem_bus_sink #(.WIDTH(16), .WAIT_CYCLES(3), .CNT_W(4)) dut3 (.Clk(Clk), .Reset(Reset), .bus(b3));

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle_all();
    b2.Bus = '0; b2.LD_MAR = 0; b2.LD_MDR = 0; b2.MIO_EN = 0; b2.Mem_Req = 0; b2.Mem_Wr = 0; b2.Mem_RData = '0;
    b1.Bus = '0; b1.LD_MAR = 0; b1.LD_MDR = 0; b1.MIO_EN = 0; b1.Mem_Req = 0; b1.Mem_Wr = 0; b1.Mem_RData = '0;
    b3.Bus = '0; b3.LD_MAR = 0; b3.LD_MDR = 0; b3.MIO_EN = 0; b3.Mem_Req = 0; b3.Mem_Wr = 0; b3.Mem_RData = '0;
  endtask

  task automatic get(input int w, output logic ce_n, output logic oe_n, output logic we_n,
                     output logic bsy, output logic dn);
    case (w)
      1:       begin ce_n = b1.Mem_CE_N; oe_n = b1.Mem_OE_N; we_n = b1.Mem_WE_N; bsy = b1.Busy; dn = b1.Mem_Done; end
      3:       begin ce_n = b3.Mem_CE_N; oe_n = b3.Mem_OE_N; we_n = b3.Mem_WE_N; bsy = b3.Busy; dn = b3.Mem_Done; end
      default: begin ce_n = b2.Mem_CE_N; oe_n = b2.Mem_OE_N; we_n = b2.Mem_WE_N; bsy = b2.Busy; dn = b2.Mem_Done; end
    endcase
  endtask

  task automatic set_req(input int w, input logic r);
    case (w)
      1:       b1.Mem_Req = r;
      3:       b3.Mem_Req = r;
      default: b2.Mem_Req = r;
    endcase
  endtask

  task automatic test_reset();
    Reset = 1; b2.LD_MAR = 1; b2.Bus = 16'hBEEF;
    step();
    total++; if (b2.MAR !== 16'h0000) $display("FAIL reset_mar got %h want 0000", b2.MAR); else pass++;
    total++; if (b2.MDR !== 16'h0000) $display("FAIL reset_mdr got %h want 0000", b2.MDR); else pass++;
    total++; if ({b2.Mem_CE_N, b2.Mem_OE_N, b2.Mem_WE_N} !== 3'b111)
      $display("FAIL reset_strobes got %b want 111", {b2.Mem_CE_N, b2.Mem_OE_N, b2.Mem_WE_N}); else pass++;
    total++; if ({b2.Busy, b2.Mem_Done} !== 2'b00)
      $display("FAIL reset_busy_done got %b want 00", {b2.Busy, b2.Mem_Done}); else pass++;
    Reset = 0;
    step();
    total++; if (b2.MAR !== 16'hBEEF) $display("FAIL post_reset_load got %h want beef", b2.MAR); else pass++;
    b2.LD_MAR = 0;
  endtask

  task automatic test_read();
    int str = 0, first = 0, bsy_n = 0, dn_n = 0, dc = 0, ovl = 0;
    logic [15:0] mdr_d = '0;
    b2.Bus = 16'h0030; b2.LD_MAR = 1;
    step();
    b2.LD_MAR = 0; b2.Mem_RData = 16'h1234; b2.Mem_Req = 1; b2.Mem_Wr = 0;
    step();
    b2.Mem_Req = 0;
    for (int c = 1; c <= 6; c++) begin
      if (!b2.Mem_CE_N && !b2.Mem_OE_N) begin str++; if (first == 0) first = c; end
      if (!b2.Mem_OE_N && !b2.Mem_WE_N) ovl++;
      if (b2.Busy) bsy_n++;
      if (b2.Mem_Done) begin dn_n++; dc = c; mdr_d = b2.MDR; end
      step();
    end
    total++; if (b2.Mem_Addr !== 16'h0030) $display("FAIL read_addr got %h want 0030", b2.Mem_Addr); else pass++;
    total++; if (str !== 2) $display("FAIL read_strobe_width got %0d want 2", str); else pass++;
    total++; if (first !== 1) $display("FAIL read_strobe_start got %0d want 1", first); else pass++;
    total++; if (bsy_n !== 3) $display("FAIL read_busy_cycles got %0d want 3", bsy_n); else pass++;
    total++; if (dn_n !== 1) $display("FAIL read_done_count got %0d want 1", dn_n); else pass++;
    total++; if (dc !== 3) $display("FAIL read_done_cycle got %0d want 3", dc); else pass++;
    total++; if (mdr_d !== 16'h1234) $display("FAIL read_mdr got %h want 1234", mdr_d); else pass++;
    total++; if (ovl !== 0) $display("FAIL read_oe_we_overlap got %0d want 0", ovl); else pass++;
  endtask

  task automatic test_write();
    int we = 0, oe = 0, dn_n = 0, dc = 0;
    logic [15:0] addr = '0, wd = '0;
    b2.Bus = 16'h0040; b2.LD_MAR = 1;
    step();
    b2.LD_MAR = 0; b2.Bus = 16'h00A5; b2.LD_MDR = 1; b2.MIO_EN = 0;
    step();
    b2.LD_MDR = 0; b2.Mem_Req = 1; b2.Mem_Wr = 1;
    step();
    b2.Mem_Req = 0; b2.Mem_Wr = 0;
    for (int c = 1; c <= 6; c++) begin
      if (c == 1) begin addr = b2.Mem_Addr; wd = b2.Mem_WData; end
      if (!b2.Mem_CE_N && !b2.Mem_WE_N) we++;
      if (!b2.Mem_OE_N) oe++;
      if (b2.Mem_Done) begin dn_n++; dc = c; end
      step();
    end
    total++; if (addr !== 16'h0040) $display("FAIL write_addr got %h want 0040", addr); else pass++;
    total++; if (wd !== 16'h00A5) $display("FAIL write_wdata got %h want 00a5", wd); else pass++;
    total++; if (we !== 2) $display("FAIL write_we_width got %0d want 2", we); else pass++;
    total++; if (oe !== 0) $display("FAIL write_oe_active got %0d want 0", oe); else pass++;
    total++; if (dn_n !== 1 || dc !== 3) $display("FAIL write_done got count %0d cycle %0d want 1 at 3", dn_n, dc); else pass++;
  endtask

  task automatic test_lockout();
    int mar_bad = 0, we = 0, dn_n = 0;
    logic [15:0] mdr_d = '0;
    // MAR load in the request cycle must be used by that same access.
    b2.Bus = 16'h0050; b2.LD_MAR = 1; b2.Mem_Req = 1; b2.Mem_Wr = 0; b2.Mem_RData = 16'h5678;
    step();
    b2.Bus = 16'hFFFF; b2.LD_MDR = 1; b2.MIO_EN = 0; b2.Mem_Wr = 1;
    for (int c = 1; c <= 6; c++) begin
      if (b2.MAR !== 16'h0050) mar_bad++;
      if (!b2.Mem_WE_N) we++;
      if (b2.Mem_Done) begin dn_n++; mdr_d = b2.MDR; end
      if (c == 3) begin b2.LD_MAR = 0; b2.LD_MDR = 0; b2.Mem_Req = 0; b2.Mem_Wr = 0; end
      step();
    end
    total++; if (mar_bad !== 0) $display("FAIL lockout_mar_changed got %0d want 0", mar_bad); else pass++;
    total++; if (we !== 0) $display("FAIL lockout_wr_resampled got %0d want 0", we); else pass++;
    total++; if (dn_n !== 1) $display("FAIL lockout_done_count got %0d want 1", dn_n); else pass++;
    total++; if (mdr_d !== 16'h5678) $display("FAIL lockout_mdr got %h want 5678", mdr_d); else pass++;
    total++; if (b2.MDR !== 16'h5678 || b2.Busy !== 1'b0)
      $display("FAIL lockout_final got mdr %h busy %b want 5678 0", b2.MDR, b2.Busy); else pass++;
  endtask

  task automatic test_reset_mid();
    int dn_n = 0;
    logic [15:0] mdr_d = '0;
    b2.Mem_RData = 16'h9999; b2.Mem_Req = 1; b2.Mem_Wr = 0;
    step();
    b2.Mem_Req = 0;
    total++; if (b2.Busy !== 1'b1 || b2.Mem_OE_N !== 1'b0)
      $display("FAIL midrst_in_read got busy %b oe_n %b want 1 0", b2.Busy, b2.Mem_OE_N); else pass++;
    Reset = 1;
    step();
    Reset = 0;
    total++; if ({b2.Mem_CE_N, b2.Mem_OE_N, b2.Mem_WE_N} !== 3'b111)
      $display("FAIL midrst_strobes got %b want 111", {b2.Mem_CE_N, b2.Mem_OE_N, b2.Mem_WE_N}); else pass++;
    total++; if (b2.MDR !== 16'h0000 || b2.Busy !== 1'b0)
      $display("FAIL midrst_state got mdr %h busy %b want 0000 0", b2.MDR, b2.Busy); else pass++;
    for (int c = 0; c < 4; c++) begin
      if (b2.Mem_Done) dn_n++;
      step();
    end
    total++; if (dn_n !== 0) $display("FAIL midrst_spurious_done got %0d want 0", dn_n); else pass++;
    b2.Mem_Req = 1;
    step();
    b2.Mem_Req = 0;
    for (int c = 1; c <= 5; c++) begin
      if (b2.Mem_Done) begin dn_n++; mdr_d = b2.MDR; end
      step();
    end
    total++; if (dn_n !== 1 || mdr_d !== 16'h9999)
      $display("FAIL midrst_reread got done %0d mdr %h want 1 9999", dn_n, mdr_d); else pass++;
  endtask

  task automatic test_back_to_back(input int w);
    int str = 0, s1 = 0, gap = 0, dn_n = 0, d1 = 0, d2 = 0;
    logic ce_n, oe_n, we_n, bsy, dn;
    set_req(w, 1);
    step();
    for (int c = 1; c <= 2 * w + 4; c++) begin
      get(w, ce_n, oe_n, we_n, bsy, dn);
      if (!ce_n && !oe_n) begin str++; if (c <= w + 1) s1++; end
      if (!bsy && c <= 2 * w + 3) gap++;
      if (dn) begin dn_n++; if (d1 == 0) d1 = c; else d2 = c; end
      if (c == w + 3) set_req(w, 0);
      step();
    end
    total++; if (s1 !== w) $display("FAIL b2b_w%0d_first_width got %0d want %0d", w, s1, w); else pass++;
    total++; if (str !== 2 * w) $display("FAIL b2b_w%0d_total_strobe got %0d want %0d", w, str, 2 * w); else pass++;
    total++; if (gap !== 1) $display("FAIL b2b_w%0d_idle_gap got %0d want 1", w, gap); else pass++;
    total++; if (dn_n !== 2 || d1 !== w + 1 || d2 !== 2 * w + 3)
      $display("FAIL b2b_w%0d_done got count %0d at %0d,%0d want 2 at %0d,%0d", w, dn_n, d1, d2, w + 1, 2 * w + 3);
    else pass++;
  endtask

  initial begin
    idle_all();
    test_reset();
    test_read();
    test_write();
    test_lockout();
    test_reset_mid();
    test_back_to_back(1);
    test_back_to_back(3);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/mem_bus_sink.md
Name: mem_bus_sink

Overview:
- Receiving end of the datapath bus. It captures the gated 16-bit bus value into MAR and MDR.
- Runs SRAM read/write transactions with a fixed wait-state count.
- On a read, loads MDR from memory and pulses a completion strobe to the control FSM.
- Sits between the bus gate muxes and the off-chip/on-chip SRAM interface.

Parameters:
- WIDTH, 16, data/address width of bus, MAR, MDR
- WAIT_CYCLES, 2, cycles the memory strobe is held asserted per access (legal range 1..15)
- CNT_W, 4, width of the wait-state counter (must hold WAIT_CYCLES)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset  in  1  synchronous, active-high
- Bus  in  WIDTH  current datapath bus value
- LD_MAR  in  1  load MAR from Bus
- LD_MDR  in  1  load MDR (source chosen by MIO_EN)
- MIO_EN  in  1  MDR load source: 0 = Bus, 1 = Mem_RData
- Mem_Req  in  1  start memory transaction (sampled in IDLE only)
- Mem_Wr  in  1  transaction type with Mem_Req: 1 = write, 0 = read
- Mem_RData  in  WIDTH  SRAM read data
- MAR  out  WIDTH  memory address register
- MDR  out  WIDTH  memory data register
- Mem_Addr  out  WIDTH  address to SRAM (= MAR)
- Mem_WData  out  WIDTH  write data to SRAM (= MDR)
- Mem_CE_N  out  1  chip enable, active-low
- Mem_OE_N  out  1  output enable, active-low
- Mem_WE_N  out  1  write enable, active-low
- Busy  out  1  high while not in IDLE
- Mem_Done  out  1  one-cycle completion pulse

Behaviour:
- Reset values:
  - MAR = 0, MDR = 0.
  - Mem_CE_N = Mem_OE_N = Mem_WE_N = 1.
  - Busy = 0, Mem_Done = 0.
  - State = IDLE, counter = 0.
- Reset asserted mid-transaction forces all of the above on the next edge. No partial MDR update.
- FSM states are IDLE, READ, WRITE, DONE. All outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- IDLE:
  - LD_MAR=1: MAR <= Bus.
  - LD_MDR=1: MDR <= (MIO_EN ? Mem_RData : Bus).
  - Both loads are allowed in the same cycle.
  - Mem_Req=1 moves to READ (Mem_Wr=0) or WRITE (Mem_Wr=1) and clears the counter. Loads in that same cycle still take effect, so the transaction uses the new MAR/MDR.
- READ:
  - Mem_CE_N = 0, Mem_OE_N = 0. Counter increments each cycle.
  - On the cycle where counter == WAIT_CYCLES-1: MDR <= Mem_RData, then go to DONE.
- WRITE:
  - Mem_CE_N = 0, Mem_WE_N = 0, Mem_OE_N = 1. Counter increments each cycle.
  - At counter == WAIT_CYCLES-1, go to DONE.
- DONE: Mem_Done = 1 for exactly one cycle, strobes deasserted, then return to IDLE.
- Latency: Mem_Req sampled at edge N.
  - Strobes are active during cycles N+1 .. N+WAIT_CYCLES.
  - Mem_Done is high in cycle N+WAIT_CYCLES+1.
  - A new request is accepted at the earliest in that cycle + 1.
- Busy = 1 in READ, WRITE and DONE.
- While Busy:
  - LD_MAR, LD_MDR and Mem_Req are ignored, so MAR/MDR are stable during the access.
  - Mem_Wr is not re-sampled.
- Mem_Addr and Mem_WData are continuous copies of MAR and MDR.
- Mem_OE_N and Mem_WE_N are never both 0.
- Counter does not wrap in legal use. WAIT_CYCLES outside 1..15 is a configuration error, flagged by an elaboration assertion.

Decomposition:
- Shared package (slc3_pkg):
  - Enum typedef mem_state_t {IDLE, READ, WRITE, DONE}.
  - Constant BUS_W = 16.
  - Constant DEFAULT_MEM_WAIT = 2.
- One natural sub-module: ld_reg (WIDTH-parameterised register with synchronous Reset and load enable), instantiated for MAR and MDR. The MDR input is selected by the existing mux_2t1.

Test Plan:
- Reset: drive LD_MAR=1 with Bus=16'hBEEF while Reset=1 → MAR = 0, MDR = 0, all strobes 1, Busy = 0. After Reset drops, a load captures 16'hBEEF.
- Read, WAIT_CYCLES=2:
  - Stimulus: MAR=16'h0030, Mem_Req=1, Mem_Wr=0, Mem_RData=16'h1234.
  - Mem_OE_N/CE_N = 0 for exactly 2 cycles.
  - MDR = 16'h1234 when Mem_Done pulses in cycle 3.
  - Busy is high for 3 cycles.
- Write:
  - Stimulus: same-cycle LD_MAR (Bus=16'h0040), then LD_MDR (MIO_EN=0, Bus=16'h00A5), then Mem_Req with Mem_Wr=1.
  - Mem_Addr = 16'h0040, Mem_WData = 16'h00A5, Mem_WE_N = 0 for 2 cycles, Mem_OE_N stays 1.
  - Mem_Done = 1 for one cycle.
- Busy lockout: during a read, assert LD_MAR (Bus=16'hFFFF), LD_MDR and Mem_Req → MAR is unchanged and no second transaction starts. Mem_Done pulses exactly once.
- Reset mid-read: assert Reset in the first READ cycle → strobes return to 1 next edge, MDR = 0, no Mem_Done pulse. A subsequent read completes normally.
- Back-to-back: issue Mem_Req in the cycle after Mem_Done, with WAIT_CYCLES=1 and WAIT_CYCLES=3 builds → strobe widths are 1 and 3 cycles, and IDLE gaps are exactly 1 cycle.
